// File: rtl/branch_resolve_if.sv
// Branch-prediction handshake between the core pipeline (master) and the
// branch resolution unit (slave): ID push side, RR resolve side, debug outputs.
interface branch_resolve_if #(
  parameter int unsigned W = 16
);
  logic         id_valid;
  logic [3:0]   opcodeID;
  logic [W-1:0] pcID;
  logic [5:0]   imm6ID;
  logic         pred_taken;
  logic         rr_valid;
  logic [3:0]   opcodeIDRR;
  logic [W-1:0] rdata1;
  logic [W-1:0] rdata2;
  logic         flush;
  logic [W-1:0] redirect_pc;
  logic         stall_id;
  logic [3:0]   inflight;
  logic         err_underflow;
  logic         err_overflow;
  logic [15:0]  branch_cnt;
  logic [15:0]  mispredict_cnt;

  modport master (
    output id_valid, opcodeID, pcID, imm6ID, pred_taken,
    output rr_valid, opcodeIDRR, rdata1, rdata2,
    input  flush, redirect_pc, stall_id, inflight,
    input  err_underflow, err_overflow, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  id_valid, opcodeID, pcID, imm6ID, pred_taken,
    input  rr_valid, opcodeIDRR, rdata1, rdata2,
    output flush, redirect_pc, stall_id, inflight,
    output err_underflow, err_overflow, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Tracks beq branches predicted in ID in an in-order queue, resolves them in RR
// and issues a registered flush/redirect on misprediction.
module branch_resolve #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned W            = 16,
  parameter logic [3:0]  OP_BEQ       = 4'h8
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);
  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_L = 4'(DEPTH);
  localparam logic [2:0]  FLUSH_L = 3'(FLUSH_CYCLES);
  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_FLUSH = 1'b1;

  logic [W-1:0]     pc_q  [DEPTH];
  logic [W-1:0]     tgt_q [DEPTH];
  logic [DEPTH-1:0] pred_q;

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [3:0]    occ_r;
  logic [0:0]    state_r;
  logic [2:0]    fcnt_r;
  logic          flush_r;
  logic [W-1:0]  redirect_r;
  logic          err_uf_r;
  logic          err_of_r;
  logic [15:0]   bcnt_r;
  logic [15:0]   mcnt_r;

  logic          push_req_s;
  logic          resolve_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          actual_s;
  logic          mispredict_s;
  logic          push_s;
  logic          overflow_s;
  logic [W-1:0]  target_s;
  logic [W-1:0]  head_pc_s;
  logic [W-1:0]  head_tgt_s;
  logic          head_pred_s;
  logic [W-1:0]  redirect_s;

  // Per-cycle event decode from the current state and both pipeline stages.
  always_comb begin
    push_req_s   = bus.id_valid && (bus.opcodeID == OP_BEQ) && (state_r == S_IDLE);
    resolve_s    = bus.rr_valid && (bus.opcodeIDRR == OP_BEQ) && (state_r == S_IDLE);
    empty_s      = (occ_r == 4'd0);
    full_s       = (occ_r == DEPTH_L);
    pop_s        = resolve_s && !empty_s;
    head_pc_s    = pc_q[head_r];
    head_tgt_s   = tgt_q[head_r];
    head_pred_s  = pred_q[head_r];
    actual_s     = (bus.rdata1 == bus.rdata2);
    mispredict_s = pop_s && (actual_s != head_pred_s);
    // A mispredict squashes the same-cycle push as wrong-path.
    push_s       = push_req_s && !mispredict_s && (!full_s || pop_s);
    overflow_s   = push_req_s && full_s && !pop_s;
    target_s     = bus.pcID + {{(W-6){bus.imm6ID[5]}}, bus.imm6ID};
    if (actual_s) begin
      redirect_s = head_tgt_s;
    end else begin
      redirect_s = head_pc_s + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Queue payload; written at the tail, never reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_q[tail_r]   <= bus.pcID;
      tgt_q[tail_r]  <= target_s;
      pred_q[tail_r] <= bus.pred_taken;
    end
  end

  // Control state, pointers, flags and statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r     <= '0;
      tail_r     <= '0;
      occ_r      <= 4'd0;
      state_r    <= S_IDLE;
      fcnt_r     <= 3'd0;
      flush_r    <= 1'b0;
      redirect_r <= '0;
      err_uf_r   <= 1'b0;
      err_of_r   <= 1'b0;
      bcnt_r     <= 16'd0;
      mcnt_r     <= 16'd0;
    end else begin
      flush_r  <= mispredict_s;
      err_uf_r <= err_uf_r | (resolve_s & empty_s);
      err_of_r <= err_of_r | overflow_s;
      if (pop_s && (bcnt_r != 16'hFFFF)) bcnt_r <= bcnt_r + 16'd1;
      if (mispredict_s) begin
        if (mcnt_r != 16'hFFFF) mcnt_r <= mcnt_r + 16'd1;
        redirect_r <= redirect_s;
        head_r     <= '0;
        tail_r     <= '0;
        occ_r      <= 4'd0;
        state_r    <= S_FLUSH;
        fcnt_r     <= FLUSH_L;
      end else begin
        if (pop_s)  head_r <= head_r + PW'(1);
        if (push_s) tail_r <= tail_r + PW'(1);
        occ_r <= occ_r + {3'd0, push_s} - {3'd0, pop_s};
        case (state_r)
          S_IDLE: begin
            fcnt_r <= fcnt_r;
          end
          S_FLUSH: begin
            fcnt_r <= fcnt_r - 3'd1;
            if (fcnt_r == 3'd1) state_r <= S_IDLE;
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.flush          = flush_r;
  assign bus.redirect_pc    = redirect_r;
  assign bus.stall_id       = full_s && !resolve_s;
  assign bus.inflight       = occ_r;
  assign bus.err_underflow  = err_uf_r;
  assign bus.err_overflow   = err_of_r;
  assign bus.branch_cnt     = bcnt_r;
  assign bus.mispredict_cnt = mcnt_r;
endmodule
